// File: rtl/kp_adapt.sv
// kp_adapt: adaptive gain register for the NN decision stage.
// Steps kp by a signed increment once per update tick, clamps it to
// [KP_MIN, KP_MAX], and slows the tick rate 4x once the increment
// direction has been oscillating long enough to call the loop locked.
module kp_adapt #(
    parameter int         UPD_DIV    = 16,
    parameter logic [7:0] KP_MIN     = 8'd1,
    parameter logic [7:0] KP_MAX     = 8'd254,
    parameter logic [7:0] KP_RST     = 8'd128,
    parameter int         LOCK_CNT   = 8,
    parameter int         UNLOCK_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] kp_init,
    input  logic [7:0] inc,
    output logic [7:0] kp,
    output logic       kp_upd,
    output logic       sat,
    output logic       locked
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [9:0] PER_TRACK = 10'(UPD_DIV);
    localparam logic [9:0] PER_LOCK  = 10'(4 * UPD_DIV);
    localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_CNT);

    // Saturate a 10-bit signed candidate into the legal kp window.
    function automatic logic [7:0] clamp_val(input logic signed [9:0] v);
        logic [7:0] res;
        if (v < $signed({2'b00, KP_MIN})) begin
            res = KP_MIN;
        end else if (v > $signed({2'b00, KP_MAX})) begin
            res = KP_MAX;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    // A degenerate window (KP_MIN==KP_MAX) reports every update as clamped.
    function automatic logic out_of_range(input logic signed [9:0] v);
        logic res;
        if (KP_MIN == KP_MAX) begin
            res = 1'b1;
        end else if ((v < $signed({2'b00, KP_MIN})) || (v > $signed({2'b00, KP_MAX}))) begin
            res = 1'b1;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    state_t            r_state;
    logic [7:0]        r_kp;
    logic [9:0]        r_div;
    logic [3:0]        r_rev;
    logic [3:0]        r_same;
    logic              r_prev_dir;
    logic              r_prev_vld;
    logic              r_upd;
    logic              r_sat;
    logic              r_locked;

    state_t            w_state_nx;
    logic [7:0]        w_kp_nx;
    logic [9:0]        w_div_nx;
    logic [9:0]        w_period;
    logic [3:0]        w_rev_nx;
    logic [3:0]        w_same_nx;
    logic [3:0]        w_rev_cand;
    logic [3:0]        w_same_cand;
    logic              w_dir_nx;
    logic              w_vld_nx;
    logic              w_upd_nx;
    logic              w_sat_nx;
    logic              w_tick;
    logic              w_nz;
    logic signed [9:0] w_sum;

    assign w_period = (r_state == ST_LOCKED) ? PER_LOCK : PER_TRACK;
    assign w_tick   = (r_state != ST_IDLE) && en && (r_div == (w_period - 10'd1));
    assign w_nz     = (inc != 8'd0);
    assign w_sum    = $signed({2'b00, r_kp}) + $signed({{2{inc[7]}}, inc});

    // Next-state, divider, direction tracking and update pulses.
    always_comb begin
        w_state_nx  = r_state;
        w_kp_nx     = r_kp;
        w_div_nx    = r_div;
        w_rev_nx    = r_rev;
        w_same_nx   = r_same;
        w_dir_nx    = r_prev_dir;
        w_vld_nx    = r_prev_vld;
        w_upd_nx    = 1'b0;
        w_sat_nx    = 1'b0;
        w_rev_cand  = 4'd0;
        w_same_cand = 4'd0;
        if (load) begin
            // Load wins over any coincident tick and restarts all tracking.
            w_state_nx = en ? ST_TRACK : ST_IDLE;
            w_kp_nx    = clamp_val($signed({2'b00, kp_init}));
            w_div_nx   = 10'd0;
            w_rev_nx   = 4'd0;
            w_same_nx  = 4'd0;
            w_dir_nx   = 1'b0;
            w_vld_nx   = 1'b0;
            w_upd_nx   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        w_state_nx = ST_TRACK;
                        w_div_nx   = 10'd0;
                        w_rev_nx   = 4'd0;
                        w_same_nx  = 4'd0;
                        w_dir_nx   = 1'b0;
                        w_vld_nx   = 1'b0;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_TRACK, ST_LOCKED: begin
                    if (!en) begin
                        w_state_nx = ST_IDLE;
                        w_div_nx   = 10'd0;
                    end else if (w_tick) begin
                        w_div_nx = 10'd0;
                        w_kp_nx  = clamp_val(w_sum);
                        w_upd_nx = 1'b1;
                        w_sat_nx = out_of_range(w_sum);
                        if (w_nz) begin
                            w_dir_nx = inc[7];
                            w_vld_nx = 1'b1;
                            if (r_state == ST_TRACK) begin
                                // First direction after entry has nothing to reverse against.
                                if (r_prev_vld && (inc[7] != r_prev_dir)) begin
                                    w_rev_cand = (r_rev == 4'd15) ? 4'd15 : r_rev + 4'd1;
                                end else begin
                                    w_rev_cand = 4'd0;
                                end
                                w_rev_nx = w_rev_cand;
                                if (w_rev_cand == LOCK_TH) begin
                                    w_state_nx = ST_LOCKED;
                                    w_same_nx  = 4'd0;
                                end else begin
                                    w_state_nx = ST_TRACK;
                                end
                            end else begin
                                if (inc[7] == r_prev_dir) begin
                                    w_same_cand = (r_same == 4'd15) ? 4'd15 : r_same + 4'd1;
                                end else begin
                                    w_same_cand = 4'd0;
                                end
                                w_same_nx = w_same_cand;
                                if (w_same_cand == UNLOCK_TH) begin
                                    w_state_nx = ST_TRACK;
                                    w_rev_nx   = 4'd0;
                                    w_same_nx  = 4'd0;
                                end else begin
                                    w_state_nx = ST_LOCKED;
                                end
                            end
                        end else begin
                            w_dir_nx = r_prev_dir;
                        end
                    end else begin
                        w_div_nx = r_div + 10'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_div_nx   = 10'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_kp       <= KP_RST;
            r_div      <= 10'd0;
            r_rev      <= 4'd0;
            r_same     <= 4'd0;
            r_prev_dir <= 1'b0;
            r_prev_vld <= 1'b0;
            r_upd      <= 1'b0;
            r_sat      <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_kp       <= w_kp_nx;
            r_div      <= w_div_nx;
            r_rev      <= w_rev_nx;
            r_same     <= w_same_nx;
            r_prev_dir <= w_dir_nx;
            r_prev_vld <= w_vld_nx;
            r_upd      <= w_upd_nx;
            r_sat      <= w_sat_nx;
            r_locked   <= (w_state_nx == ST_LOCKED);
        end
    end

    assign kp     = r_kp;
    assign kp_upd = r_upd;
    assign sat    = r_sat;
    assign locked = r_locked;
endmodule

// File: doc/kp_adapt.md
KP_ADAPT -- requirements
Module: kp_adapt

Interface
REQ-001 SHALL have parameter UPD_DIV, default 16: clock cycles per update tick in TRACK, legal range 1..255.
REQ-002 SHALL have parameter KP_MIN, default 8'd1: lower saturation bound for kp.
REQ-003 SHALL have parameter KP_MAX, default 8'd254: upper saturation bound, KP_MIN <= KP_MAX.
REQ-004 SHALL have parameter KP_RST, default 8'd128: kp value after reset, within [KP_MIN, KP_MAX].
REQ-005 SHALL have parameter LOCK_CNT, default 8: consecutive direction reversals needed to declare lock, range 1..15.
REQ-006 SHALL have parameter UNLOCK_CNT, default 3: consecutive same-direction steps needed to leave lock, range 1..15.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port en, input, 1 bit: adaptation enable.
REQ-010 SHALL have port load, input, 1 bit: one-cycle request to load kp_init.
REQ-011 SHALL have port kp_init, input, 8 bits: unsigned value loaded on load.
REQ-012 SHALL have port inc, input, 8 bits: signed two's-complement step from the NN decision stage, nominally 8'h01 or 8'hFF.
REQ-013 SHALL have port kp, output, 8 bits: registered unsigned gain, fed back to the decision stage.
REQ-014 SHALL have port kp_upd, output, 1 bit: one-cycle pulse, high in the first cycle a new kp value is visible.
REQ-015 SHALL have port sat, output, 1 bit: one-cycle pulse, high alongside kp_upd when the update was clamped.
REQ-016 SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.

Function
REQ-017 SHALL implement FSM states IDLE, TRACK, LOCKED; locked = (state==LOCKED).
REQ-018 SHALL transition IDLE->TRACK on en=1, clearing the divider, rev_cnt, same_cnt and the previous-direction register.
REQ-019 SHALL transition TRACK or LOCKED to IDLE on en=0, keeping kp and producing no tick in that cycle.
REQ-020 SHALL run a 10-bit divider counting 0..T-1 in TRACK/LOCKED, with T=UPD_DIV in TRACK and T=4*UPD_DIV in LOCKED; tick = (div_cnt==T-1), then wrap to 0.
REQ-021 SHALL clear the divider on every state change, so the first tick comes T cycles after entry.
REQ-022 SHALL compute on tick: sum = {2'b00,kp} + sign-extended inc (10-bit signed); kp <= KP_MIN if sum<KP_MIN, KP_MAX if sum>KP_MAX, else sum[7:0].
REQ-023 SHALL assert kp_upd in the cycle after a tick, and assert sat in that same cycle when clamping was applied.
REQ-024 SHALL take direction = inc[7] when inc!=0; inc==0 on tick SHALL leave kp unchanged, still pulse kp_upd, and leave direction and all counters untouched.
REQ-025 SHALL, in TRACK on a nonzero tick: increment rev_cnt (saturating at 15) if direction differs from the previous direction, else clear it; store direction; go to LOCKED when rev_cnt reaches LOCK_CNT.
REQ-026 SHALL, in LOCKED on a nonzero tick: increment same_cnt if direction equals the previous direction, else clear it; go to TRACK with rev_cnt=0 when same_cnt reaches UNLOCK_CNT.
REQ-027 SHALL NOT count the first nonzero tick after entering TRACK from IDLE as a reversal (no valid previous direction).
REQ-028 SHALL, on load=1 (any state except reset): set kp <= clamp(kp_init), go to TRACK if en=1 else IDLE, clear all counters, pulse kp_upd next cycle, sat=0.
REQ-029 SHALL give load priority over a coincident tick; the tick is discarded.
REQ-030 SHALL keep kp unchanged when KP_MIN==KP_MAX, but still pulse kp_upd and sat on every tick.

Reset
REQ-031 SHALL on rst=1 set state=IDLE, kp=KP_RST, kp_upd=0, sat=0, locked=0, and all counters and the direction register to 0, taking priority over load and en.
REQ-032 SHALL, when rst is asserted mid-operation, discard any pending tick, and SHALL resume at IDLE on the first clock edge with rst=0.

Verification
REQ-033 SHALL verify: reset, en=1, inc=8'h01 held -> first kp_upd 17 cycles after en rises, kp=129, then +1 every 16 cycles.
REQ-034 SHALL verify: load with kp_init=8'd253, inc=8'h01 -> kp 254 with sat=0, next tick kp stays 254 with sat=1.
REQ-035 SHALL verify: load with kp_init=8'd0 -> kp=1; inc=8'hFF -> kp stays 1 with sat=1 on every tick.
REQ-036 SHALL verify: inc alternating 8'h01/8'hFF on each tick -> locked rises after the 9th tick (8 reversals), then ticks spaced 64 cycles; three consecutive 8'h01 ticks -> locked falls and spacing returns to 16.
REQ-037 SHALL verify: load coincident with a tick at kp=100, kp_init=50 -> kp=50, a single kp_upd pulse, and the next tick 16 cycles later.
REQ-038 SHALL verify: rst asserted one cycle before a tick while LOCKED -> no kp_upd, kp=128, locked=0 after the reset edge.
